// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame bit positions,
// deframer FSM states and the layout of one buffered receive entry.
package uart_pkg;

  localparam int FRM_START    = 0;
  localparam int FRM_DATA_LSB = 1;
  localparam int FRM_PAR      = 9;
  localparam int FRM_STOP     = 10;
  localparam int FRM_WIDTH    = 11;
  localparam int ENTRY_WIDTH  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    STORE = 2'd2
  } rx_state_e;

  // One FIFO entry: frame error, parity error, then the data byte.
  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  // True when the data+parity bits do not match the selected parity sense.
  function automatic logic parity_mismatch(input logic [FRM_WIDTH-1:0] frame,
                                           input logic                 odd);
    return (^frame[FRM_PAR:FRM_DATA_LSB]) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is shown
// combinationally from storage; pointers carry one extra MSB so full and
// empty can be told apart when the low bits match.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     baud_clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pop only when something is stored; push when there is room or a slot is
  // being freed by a pop in the same cycle.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Storage and pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx_deframe.sv
// Receive deframer: catches the receiver's frame-complete pulse, checks
// start/stop/parity, and queues the data byte with its error flags in a
// small FWFT FIFO drained by the register block. Lost frames set a sticky
// overrun flag.
module uart_rx_deframe
  import uart_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          baud_clk,
  input  logic                          reset_n,
  input  logic [FRM_WIDTH-1:0]          frame_in,
  input  logic                          frame_done,
  input  logic                          rx_read,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          busy
);

  rx_state_e            state_q, state_d;
  logic [FRM_WIDTH-1:0] frame_q, frame_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done_prev_q;
  logic                 done_edge;
  logic                 overrun_set;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  rx_entry_t            push_entry;
  rx_entry_t            head_entry;

  // Sequence each captured frame through check and store, flag frames lost
  // to a busy pipeline or a full FIFO.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    pe_d        = pe_q;
    fe_d        = fe_q;
    fifo_push   = 1'b0;
    overrun_set = 1'b0;
    done_edge   = frame_done & ~frame_done_prev_q;
    fifo_pop    = rx_read & ~fifo_empty;
    push_entry  = '{fe: fe_q, pe: pe_q, data: frame_q[FRM_DATA_LSB +: 8]};
    case (state_q)
      IDLE: begin
        if (done_edge) begin
          frame_d = frame_in;
          state_d = CHECK;
        end
      end
      CHECK: begin
        pe_d    = PARITY_EN & parity_mismatch(frame_q, PARITY_ODD);
        fe_d    = frame_q[FRM_START] | ~frame_q[FRM_STOP];
        state_d = STORE;
      end
      STORE: begin
        if (~fifo_full | fifo_pop) begin
          fifo_push = 1'b1;
        end else begin
          overrun_set = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (done_edge && (state_q != IDLE)) begin
      overrun_set = 1'b1;
    end
    overrun_d = overrun_set | (overrun_q & ~err_clr);
  end

  // State, captured frame, error flags and edge-detect registers.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      frame_q           <= 11'h7FF;
      pe_q              <= 1'b0;
      fe_q              <= 1'b0;
      overrun_q         <= 1'b0;
      frame_done_prev_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      frame_q           <= frame_d;
      pe_q              <= pe_d;
      fe_q              <= fe_d;
      overrun_q         <= overrun_d;
      frame_done_prev_q <= frame_done;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .wdata    (push_entry),
    .pop      (rx_read),
    .rdata    (head_entry),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (rx_level)
  );

  assign rx_valid      = ~fifo_empty;
  assign rx_data       = fifo_empty ? 8'h00 : head_entry.data;
  assign rx_parity_err = ~fifo_empty & head_entry.pe;
  assign rx_frame_err  = ~fifo_empty & head_entry.fe;
  assign rx_overrun    = overrun_q;
  assign busy          = (state_q != IDLE);

endmodule
